// File: rtl/timer_irq_pkg.sv
// Shared definitions for the timer interrupt scheduler.
//   - Register word offsets (PADDR[3:2]) for the APB slave port.
//   - Scheduler FSM state encoding.
package timer_irq_pkg;

  // Word offsets: 0x0 MASK, 0x4 PENDING, 0x8 STATUS, 0xC SWSET
  localparam logic [1:0] MASK_OFS  = 2'd0;
  localparam logic [1:0] PEND_OFS  = 2'd1;
  localparam logic [1:0] STAT_OFS  = 2'd2;
  localparam logic [1:0] SWSET_OFS = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } sched_state_e;

endpackage

// File: rtl/timer_irq_rr_arb.sv
// Combinational round-robin picker.
//   eligible_i   : candidate sources
//   last_grant_i : most recently granted source; search starts just after it
//   valid_o      : at least one candidate present
//   idx_o        : first candidate strictly after last_grant_i, wrapping
// Rotate the request vector so the search start lands at bit 0, take the
// lowest set bit, then add the start offset back modulo NUM_SRC.
module timer_irq_rr_arb #(
  parameter  int NUM_SRC = 4,
  localparam int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] eligible_i,
  input  logic [ID_W-1:0]    last_grant_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    idx_o
);

  // One extra bit so start + offset (up to 2*NUM_SRC-2) never overflows
  localparam logic [ID_W:0] NSRC = (ID_W+1)'(NUM_SRC);

  logic [ID_W:0]          start;
  logic [ID_W:0]          enc;
  logic [ID_W:0]          sum;
  logic [2*NUM_SRC-1:0]   dbl_sh;
  logic [NUM_SRC-1:0]     rot;

  always_comb begin
    start = {1'b0, last_grant_i} + 1'b1;
    if (start == NSRC) start = '0;
  end

  // Shifting a doubled copy gives a rotate without a variable-width wrap mux
  assign dbl_sh = {eligible_i, eligible_i} >> start;
  assign rot    = dbl_sh[NUM_SRC-1:0];

  // Descending scan so the lowest set bit is the one that sticks
  always_comb begin
    enc = '0;
    for (int i = NUM_SRC-1; i >= 0; i--) begin
      if (rot[i]) enc = (ID_W+1)'(i);
    end
  end

  always_comb begin
    sum = enc + start;
    if (sum >= NSRC) sum = sum - NSRC;
  end

  assign valid_o = |eligible_i;
  assign idx_o   = sum[ID_W-1:0];

endmodule

// File: rtl/timer_irq_sched.sv
// Timer interrupt scheduler.
// Latches rising edges of the timer bank interrupt lines into PENDING,
// gates them with MASK and presents one source at a time to the core over
// a req/ack handshake, round-robin among eligible sources.
// Ports:
//   HCLK, HRESET          : clock, async active-high reset
//   irq_i                 : per-source interrupt lines (rising edge = event)
//   irq_req_o, irq_id_o   : request to core and the requested source ID
//   irq_ack_i             : core accepts the current request
//   PADDR..PENABLE        : APB slave inputs
//   PRDATA,PREADY,PSLVERR : APB slave outputs
// Registers (PADDR[3:2]): MASK RW, PENDING R/W1C, STATUS R, SWSET W1S.
module timer_irq_sched
  import timer_irq_pkg::*;
#(
  parameter  int NUM_SRC        = 4,
  parameter  int APB_ADDR_WIDTH = 12,
  localparam int ID_W           = $clog2(NUM_SRC)
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [NUM_SRC-1:0]        irq_i,
  output logic                      irq_req_o,
  output logic [ID_W-1:0]           irq_id_o,
  input  logic                      irq_ack_i,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR
);

  sched_state_e       state_q, state_d;
  logic [NUM_SRC-1:0] irq_q, irq_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    last_q, last_d;

  logic               addr_err, acc, wr;
  logic [1:0]         ofs;
  logic [NUM_SRC-1:0] hw_set, sw_set, set_vec, w1c, ack_clr;
  logic               arb_valid;
  logic [ID_W-1:0]    arb_idx;
  logic               unused_bits;

  // ---------------- APB decode ----------------
  assign ofs      = PADDR[3:2];
  assign addr_err = |PADDR[APB_ADDR_WIDTH-1:4];
  assign acc      = PSEL & PENABLE;
  assign wr       = acc & PWRITE & ~addr_err;
  assign PREADY   = 1'b1;
  assign PSLVERR  = acc & addr_err;

  assign w1c    = (wr && ofs == PEND_OFS)  ? PWDATA[NUM_SRC-1:0] : '0;
  assign sw_set = (wr && ofs == SWSET_OFS) ? PWDATA[NUM_SRC-1:0] : '0;

  assign unused_bits = ^{PWDATA, PADDR[1:0]};

  always_comb begin
    PRDATA = '0;
    if (!addr_err) begin
      case (ofs)
        MASK_OFS: PRDATA[NUM_SRC-1:0] = mask_q;
        PEND_OFS: PRDATA[NUM_SRC-1:0] = pend_q;
        STAT_OFS: begin
          PRDATA[0]         = irq_req_o;
          PRDATA[8 +: ID_W]  = id_q;
          PRDATA[16 +: ID_W] = last_q;
        end
        default: ;  // SWSET reads 0
      endcase
    end
  end

  // ---------------- edge detect / mask ----------------
  assign irq_d   = irq_i;
  assign hw_set  = irq_i & ~irq_q;
  assign set_vec = hw_set | sw_set;
  assign mask_d  = (wr && ofs == MASK_OFS) ? PWDATA[NUM_SRC-1:0] : mask_q;

  // Set wins over both clear paths so an event coinciding with W1C or ack
  // is kept.
  assign pend_d = (pend_q & ~(w1c | ack_clr)) | set_vec;

  // ---------------- arbiter ----------------
  timer_irq_rr_arb #(.NUM_SRC(NUM_SRC)) u_arb (
    .eligible_i   (pend_q & mask_q),
    .last_grant_i (last_q),
    .valid_o      (arb_valid),
    .idx_o        (arb_idx)
  );

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    last_d  = last_q;
    ack_clr = '0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          id_d    = arb_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          ack_clr[id_q] = 1'b1;
          last_d        = id_q;
          state_d       = IDLE;
        end else if (w1c[id_q] && !set_vec[id_q]) begin
          // Software withdrew the active source; no grant recorded.
          // Masking alone deliberately does not withdraw.
          state_d = IDLE;
        end
      end
    endcase
  end

  assign irq_req_o = (state_q == REQ);
  assign irq_id_o  = id_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= IDLE;
      irq_q   <= '0;
      mask_q  <= '0;
      pend_q  <= '0;
      id_q    <= '0;
      last_q  <= ID_W'(NUM_SRC-1);  // source 0 wins the first grant
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_timer_irq_sched.sv
module tb_timer_irq_sched;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [3:0]  irq_i;
  logic        irq_req_o;
  logic [1:0]  irq_id_o;
  logic        irq_ack_i;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;

  int errors = 0;
  int checks = 0;

  timer_irq_sched #(.NUM_SRC(4), .APB_ADDR_WIDTH(12)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .irq_i(irq_i), .irq_req_o(irq_req_o),
    .irq_id_o(irq_id_o), .irq_ack_i(irq_ack_i), .PADDR(PADDR),
    .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    tick();
    PENABLE = 1'b1;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  // Combinational read; consumes no clock edge
  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = a;
    #1;
    d = PRDATA; err = PSLVERR;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e;
    HRESET = 1'b1; irq_i = '0; irq_ack_i = 1'b0;
    PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    repeat (2) tick();
    HRESET = 1'b0;
    tick();
    checks++; if (irq_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %0h exp 0", irq_req_o); end
    checks++; if (irq_id_o !== 2'd0) begin errors++; $display("FAIL reset_id: got %0h exp 0", irq_id_o); end
    checks++; if (PREADY !== 1'b1) begin errors++; $display("FAIL pready: got %0h exp 1", PREADY); end
    apb_read(12'h000, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mask: got %0h exp 0", d); end
    apb_read(12'h004, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_pend: got %0h exp 0", d); end
    apb_read(12'h008, d, e);
    checks++; if (d !== 32'h0003_0000) begin errors++; $display("FAIL reset_status: got %0h exp 30000", d); end
  endtask

  task automatic test_single();
    logic [31:0] d; logic e;
    apb_write(12'h000, 32'hF);
    irq_i = 4'h4;
    tick();
    irq_i = 4'h0;
    apb_read(12'h004, d, e);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL single_pend: got %0h exp 4", d); end
    checks++; if (irq_req_o !== 1'b0) begin errors++; $display("FAIL single_req_early: got %0h exp 0", irq_req_o); end
    tick();
    checks++; if (irq_req_o !== 1'b1 || irq_id_o !== 2'd2) begin errors++; $display("FAIL single_req: got req=%0h id=%0h exp req=1 id=2", irq_req_o, irq_id_o); end
    apb_read(12'h008, d, e);
    checks++; if (d !== 32'h0003_0201) begin errors++; $display("FAIL single_status: got %0h exp 30201", d); end
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    apb_read(12'h004, d, e);
    checks++; if (irq_req_o !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL single_ack: got req=%0h pend=%0h exp req=0 pend=0", irq_req_o, d); end
  endtask

  task automatic test_rr_order();
    logic [31:0] d; logic e;
    do_reset();
    apb_write(12'h000, 32'hF);
    irq_i = 4'hF;
    tick();
    irq_i = 4'h0;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++; if (irq_req_o !== 1'b1 || irq_id_o !== 2'(k)) begin errors++; $display("FAIL rr_grant%0d: got req=%0h id=%0h exp req=1 id=%0d", k, irq_req_o, irq_id_o, k); end
      irq_ack_i = 1'b1;
      tick();
      irq_ack_i = 1'b0;
      checks++; if (irq_req_o !== 1'b0) begin errors++; $display("FAIL rr_gap%0d: got %0h exp 0", k, irq_req_o); end
      tick();
    end
    checks++; if (irq_req_o !== 1'b0) begin errors++; $display("FAIL rr_done_req: got %0h exp 0", irq_req_o); end
    apb_read(12'h008, d, e);
    checks++; if (d[23:16] !== 8'd3) begin errors++; $display("FAIL rr_last: got %0h exp 3", d[23:16]); end
    apb_read(12'h004, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rr_pend: got %0h exp 0", d); end
  endtask

  task automatic test_mask();
    logic [31:0] d; logic e;
    apb_write(12'h000, 32'h1);
    irq_i = 4'h2;
    tick();
    irq_i = 4'h0;
    repeat (2) tick();
    apb_read(12'h004, d, e);
    checks++; if (irq_req_o !== 1'b0 || d !== 32'h2) begin errors++; $display("FAIL mask_block: got req=%0h pend=%0h exp req=0 pend=2", irq_req_o, d); end
    apb_write(12'h000, 32'h3);
    checks++; if (irq_req_o !== 1'b0) begin errors++; $display("FAIL mask_req_early: got %0h exp 0", irq_req_o); end
    tick();
    checks++; if (irq_req_o !== 1'b1 || irq_id_o !== 2'd1) begin errors++; $display("FAIL mask_unblock: got req=%0h id=%0h exp req=1 id=1", irq_req_o, irq_id_o); end
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    checks++; if (irq_req_o !== 1'b0) begin errors++; $display("FAIL mask_ack: got %0h exp 0", irq_req_o); end
  endtask

  task automatic test_withdraw();
    logic [31:0] d; logic e;
    irq_i = 4'h1;
    tick();
    irq_i = 4'h0;
    tick();
    checks++; if (irq_req_o !== 1'b1 || irq_id_o !== 2'd0) begin errors++; $display("FAIL wd_req: got req=%0h id=%0h exp req=1 id=0", irq_req_o, irq_id_o); end
    apb_write(12'h004, 32'h1);
    apb_read(12'h008, d, e);
    checks++; if (irq_req_o !== 1'b0) begin errors++; $display("FAIL wd_drop: got %0h exp 0", irq_req_o); end
    checks++; if (d[23:16] !== 8'd1) begin errors++; $display("FAIL wd_last: got %0h exp 1", d[23:16]); end
    apb_read(12'h004, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL wd_pend: got %0h exp 0", d); end
    // re-request, then a fresh rise coincides with the ack
    irq_i = 4'h1;
    tick();
    irq_i = 4'h0;
    tick();
    checks++; if (irq_req_o !== 1'b1 || irq_id_o !== 2'd0) begin errors++; $display("FAIL race_req: got req=%0h id=%0h exp req=1 id=0", irq_req_o, irq_id_o); end
    irq_i = 4'h1; irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    apb_read(12'h004, d, e);
    checks++; if (irq_req_o !== 1'b0 || d !== 32'h1) begin errors++; $display("FAIL race_keep: got req=%0h pend=%0h exp req=0 pend=1", irq_req_o, d); end
    apb_read(12'h008, d, e);
    checks++; if (d[23:16] !== 8'd0) begin errors++; $display("FAIL race_last: got %0h exp 0", d[23:16]); end
    tick();
    checks++; if (irq_req_o !== 1'b1 || irq_id_o !== 2'd0) begin errors++; $display("FAIL race_rereq: got req=%0h id=%0h exp req=1 id=0", irq_req_o, irq_id_o); end
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    repeat (2) tick();
    apb_read(12'h004, d, e);
    checks++; if (irq_req_o !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL hold_once: got req=%0h pend=%0h exp req=0 pend=0", irq_req_o, d); end
    irq_i = 4'h0;
    tick();
  endtask

  task automatic test_swset_err_reset();
    logic [31:0] d; logic e;
    apb_write(12'h000, 32'hF);
    apb_write(12'h00C, 32'h8);
    apb_read(12'h004, d, e);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL sw_pend: got %0h exp 8", d); end
    apb_read(12'h00C, d, e);
    checks++; if (d !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL sw_read: got %0h err=%0h exp 0 err=0", d, e); end
    tick();
    checks++; if (irq_req_o !== 1'b1 || irq_id_o !== 2'd3) begin errors++; $display("FAIL sw_req: got req=%0h id=%0h exp req=1 id=3", irq_req_o, irq_id_o); end
    apb_read(12'h010, d, e);
    checks++; if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL err_read: got err=%0h data=%0h exp err=1 data=0", e, d); end
    apb_write(12'h010, 32'h0);
    apb_read(12'h000, d, e);
    checks++; if (d !== 32'hF || e !== 1'b0) begin errors++; $display("FAIL err_write: got mask=%0h err=%0h exp F err=0", d, e); end
    checks++; if (irq_req_o !== 1'b1) begin errors++; $display("FAIL err_hold_req: got %0h exp 1", irq_req_o); end
    HRESET = 1'b1;
    #1;
    checks++; if (irq_req_o !== 1'b0 || irq_id_o !== 2'd0) begin errors++; $display("FAIL async_rst: got req=%0h id=%0h exp 0 0", irq_req_o, irq_id_o); end
    apb_read(12'h000, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mask: got %0h exp 0", d); end
    apb_read(12'h004, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_pend: got %0h exp 0", d); end
    apb_read(12'h008, d, e);
    checks++; if (d !== 32'h0003_0000) begin errors++; $display("FAIL rst_status: got %0h exp 30000", d); end
    tick();
    HRESET = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_order();
    test_mask();
    test_withdraw();
    test_swset_err_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_irq_sched.md
# timer_irq_sched

Interrupt scheduler for the APB timer bank: latches the per-timer overflow/compare interrupt pulses into pending bits, applies a software mask, and presents one interrupt at a time to the core with a source ID over a req/ack handshake, arbitrating round-robin among pending sources. It sits between the timer bank's `irq_o` vector and the core's interrupt input. It is configured through its own APB slave port on the same peripheral bus.

## Interface
- `NUM_SRC`, 4: number of interrupt sources (2 per timer; bit 2k = overflow, 2k+1 = compare of timer k); 2..32
- `APB_ADDR_WIDTH`, 12: APB address width
- `ID_W`, `$clog2(NUM_SRC)`: source ID width (derived, not overridden)

Ports:
- `HCLK` in 1: single clock
- `HRESET` in 1: asynchronous, active-high reset
- `irq_i` in NUM_SRC: interrupt lines from the timer bank; rising edge = event
- `irq_req_o` out 1: interrupt request to core
- `irq_id_o` out ID_W: ID of requested source; valid while `irq_req_o`=1
- `irq_ack_i` in 1: core accepts current request
- `PADDR` in APB_ADDR_WIDTH; `PWDATA` in 32; `PWRITE`, `PSEL`, `PENABLE` in 1
- `PRDATA` out 32; `PREADY` out 1; `PSLVERR` out 1

## Operation
- Registers, offsets in PADDR[3:2]: 0x0 MASK (RW, 1 = enabled), 0x4 PENDING (R; write-1-to-clear), 0x8 STATUS (R: bit0 = `irq_req_o`, bits [8+ID_W-1:8] = `irq_id_o`, bits [23:16] = last granted ID), 0xC SWSET (W; write-1-to-set pending, reads 0). Bits at or above NUM_SRC read 0 and ignore writes.
- APB: write commits on the cycle with `PSEL & PENABLE & PWRITE`. Read data is combinational from register state. `PREADY` is tied to 1. `PSLVERR`=1 in the access phase when PADDR[APB_ADDR_WIDTH-1:4] ≠ 0. An errored write has no effect.
- Edge detect: registered copy `irq_q` of `irq_i`; `irq_i & ~irq_q` sets pending. Pending is set regardless of MASK. MASK gates only arbitration.
- Priority on one bit in one cycle: hardware set beats W1C and ack-clear, so no event is lost. SWSET and hardware set OR together.
- Eligible = PENDING & MASK.
- FSM with two states:
  - IDLE: `irq_req_o`=0. If eligible ≠ 0, pick the first eligible index strictly after `last_grant`, wrapping modulo NUM_SRC. Register it into `irq_id_o` and go to REQ.
  - REQ: `irq_req_o`=1 and `irq_id_o` is held stable. On `irq_ack_i`: clear that pending bit, set `last_grant` = `irq_id_o`, go to IDLE.
  - REQ withdrawal: if the active bit is cleared by W1C, go to IDLE without ack and leave `last_grant` unchanged.
  - Masking the active source while in REQ does not withdraw the request.
- `irq_ack_i` in IDLE is ignored.

## Timing
- Reset values: `irq_req_o`=0, `irq_id_o`=0, MASK=0, PENDING=0, `irq_q`=0, `last_grant`=NUM_SRC-1 (source 0 wins first), state IDLE. `PRDATA`, `PREADY`, `PSLVERR` follow their combinational definitions.
- Latency from event to request:
  - `irq_i` rises before edge N → PENDING bit visible after edge N.
  - If the source is eligible and the FSM is in IDLE, `irq_req_o`=1 after edge N+1. Minimum latency is 2 cycles.
- Ack to next request:
  - Ack sampled at edge M → `irq_req_o`=0 after M.
  - If another source is eligible, the next request rises after M+1.
  - `irq_req_o` is therefore low for at least 1 cycle between grants.
- Asserting reset mid-request drops `irq_req_o` immediately (async) and discards all pending bits.
- Holding `irq_i` high produces one event only.

## Structure
- Package `timer_irq_pkg`: register offset constants (`MASK_OFS`, `PEND_OFS`, `STAT_OFS`, `SWSET_OFS`) and the `sched_state_e` enum {IDLE, REQ}.
- Sub-module `timer_irq_rr_arb`: combinational round-robin picker.
  - Inputs: eligible vector, `last_grant`.
  - Outputs: `valid` and `idx`.
  - Implemented by rotate, priority-encode, un-rotate.
- Top level holds the registers, the edge detector, the FSM and the APB decode.

## Test plan
- Reset, MASK=0xF, pulse `irq_i[2]` → PENDING=0x4 after 1 cycle; `irq_req_o`=1 with id=2 after 2 cycles; ack → PENDING=0, req low.
- Pulse `irq_i[3:0]`=0xF together, ack each grant immediately → grant order 0,1,2,3; req low ≥1 cycle between grants; `last_grant` (STATUS[23:16]) =3.
- MASK=0x1, pulse source 1 → no req, PENDING=0x2; then write MASK=0x3 → req with id=1 two cycles later.
- In REQ on id=0, W1C PENDING=0x1 → req drops next cycle with no ack; `last_grant` unchanged; rise of `irq_i[0]` on the same cycle as the ack → bit stays pending and is re-requested.
- SWSET write 0x8 → req id=3; read PADDR=0x10 → `PSLVERR`=1, PRDATA=0; assert HRESET while in REQ → `irq_req_o`=0 at once and all registers at their reset values.
